// File: rtl/ccsds_turbo_enc_buffer_mp.sv
// ccsds_turbo_enc_buffer_mp
// Multi-bank encoder RAM buffer: one write port, pRPORT_N read ports, each
// read port backed by its own RAM copy so all ports see the full read bank.
// Bank pointers, occupancy counter, sticky error flag and synchronous flush
// are built in, plus a per-port read-valid pipeline.
//
// Optional build macro: CCSDS_TURBO_ENC_BUF_USEDW_EN adds output ousedw,
// the raw occupancy count (0..B).
//
// Handshake: strobes (iwrite, iwfull, irempty, iread) are sampled on rising
// iclk edges with iclkena=1. iwfull/irempty are accepted only when the
// pre-update flags allow it (ofulla / oemptya low); a refused strobe sets
// oerr. ordval marks ordata valid exactly 1+pPIPE enabled cycles after iread.
module ccsds_turbo_enc_buffer_mp #(
  parameter int pADDR_W  = 8,
  parameter int pDATA_W  = 8,
  parameter int pTAG_W   = 8,
  parameter int pBNUM_W  = 1,
  parameter int pRPORT_N = 2,
  parameter int pPIPE    = 0
) (
  input  logic                         iclk,
  input  logic                         ireset,
  input  logic                         iclkena,
  input  logic                         iflush,
  input  logic                         iwrite,
  input  logic                         iwfull,
  input  logic [pADDR_W-1:0]           iwaddr,
  input  logic [pDATA_W-1:0]           iwdata,
  input  logic [pTAG_W-1:0]            iwtag,
  input  logic                         iread,
  input  logic                         irempty,
  input  logic [pRPORT_N*pADDR_W-1:0]  iraddr,
  output logic [pRPORT_N*pDATA_W-1:0]  ordata,
  output logic                         ordval,
  output logic [pTAG_W-1:0]            ortag,
  output logic                         oempty,
  output logic                         oemptya,
  output logic                         ofull,
  output logic                         ofulla,
  output logic                         oerr
`ifdef CCSDS_TURBO_ENC_BUF_USEDW_EN
  ,
  output logic [pBNUM_W:0]             ousedw
`endif
);

  localparam int lpB     = 1 << pBNUM_W;
  localparam int lpDEPTH = 1 << (pBNUM_W + pADDR_W);
  localparam logic [pBNUM_W:0] lpB_CNT = lpB[pBNUM_W:0];

  logic [pBNUM_W-1:0] r_wptr;
  logic [pBNUM_W-1:0] r_rptr;
  logic [pBNUM_W:0]   r_used;
  logic               r_err;
  logic [pPIPE:0]     r_vpipe;
  logic [pTAG_W-1:0]  r_tag [lpB];

  logic w_full_all;
  logic w_empty_all;
  logic w_acc_w;
  logic w_acc_r;
  logic w_reject;
  logic w_wr_en;
  logic w_rd_en;

  // Flags and acceptance decisions, all from the pre-update occupancy
  always_comb begin
    w_full_all  = (r_used == lpB_CNT);
    w_empty_all = (r_used == '0);
    w_acc_w     = iwfull & ~w_full_all;
    w_acc_r     = irempty & ~w_empty_all;
    w_reject    = (iwfull & w_full_all) | (irempty & w_empty_all);
    // While all banks are full the write bank aliases the read bank
    w_wr_en     = iclkena & ~iflush & iwrite & ~w_full_all;
    w_rd_en     = iclkena & iread;
  end

  assign oempty  = (r_used < lpB_CNT);
  assign oemptya = w_empty_all;
  assign ofull   = ~w_empty_all;
  assign ofulla  = w_full_all;
  assign oerr    = r_err;
  assign ordval  = r_vpipe[pPIPE];
  assign ortag   = r_tag[r_rptr];

`ifdef CCSDS_TURBO_ENC_BUF_USEDW_EN
  assign ousedw = r_used;
`endif

  // Bank pointers, occupancy counter and sticky error
  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_used <= '0;
      r_err  <= 1'b0;
    end else if (iclkena) begin
      if (iflush) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_used <= '0;
        r_err  <= 1'b0;
      end else begin
        if (w_acc_w) r_wptr <= r_wptr + 1'b1;
        if (w_acc_r) r_rptr <= r_rptr + 1'b1;
        case ({w_acc_w, w_acc_r})
          2'b10:   r_used <= r_used + 1'b1;
          2'b01:   r_used <= r_used - 1'b1;
          default: r_used <= r_used;
        endcase
        if (w_reject) r_err <= 1'b1;
      end
    end
  end

  // Read-valid delay line, length 1+pPIPE enabled cycles
  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      r_vpipe <= '0;
    end else if (iclkena) begin
      if (iflush) begin
        r_vpipe <= '0;
      end else begin
        r_vpipe[0] <= iread;
        for (int i = 1; i <= pPIPE; i++) r_vpipe[i] <= r_vpipe[i-1];
      end
    end
  end

  // Tag RAM: the tag of a bank is latched when that bank is closed
  always_ff @(posedge iclk) begin
    if (iclkena & ~iflush & w_acc_w) r_tag[r_wptr] <= iwtag;
  end

  // One data RAM copy per read port; writes broadcast to every copy
  for (genvar k = 0; k < pRPORT_N; k++) begin : g_port
    logic [pDATA_W-1:0]         r_mem [lpDEPTH];
    logic [pDATA_W-1:0]         r_q1;
    logic [pBNUM_W+pADDR_W-1:0] w_raddr;
    logic [pBNUM_W+pADDR_W-1:0] w_waddr;

    assign w_raddr = {r_rptr, iraddr[k*pADDR_W +: pADDR_W]};
    assign w_waddr = {r_wptr, iwaddr};

    // Broadcast write and registered read for this port's copy
    always_ff @(posedge iclk) begin
      if (w_wr_en) r_mem[w_waddr] <= iwdata;
      if (w_rd_en) r_q1 <= r_mem[w_raddr];
    end

    if (pPIPE != 0) begin : g_pipe
      logic [pDATA_W-1:0] r_q2;
      // Extra output register, shifts in step with the valid pipeline
      always_ff @(posedge iclk) begin
        if (iclkena) r_q2 <= r_q1;
      end
      assign ordata[k*pDATA_W +: pDATA_W] = r_q2;
    end else begin : g_nopipe
      assign ordata[k*pDATA_W +: pDATA_W] = r_q1;
    end
  end

endmodule

// File: tb/tb_ccsds_turbo_enc_buffer_mp.sv
// tb_ccsds_turbo_enc_buffer_mp
// Two instances (pPIPE=0 and pPIPE=1) share all inputs and are compared each
// cycle with a bank-level reference model: per-bank arrays, pointer/count
// integers and a history of enabled-cycle read samples for the latency.
module tb_ccsds_turbo_enc_buffer_mp;

  localparam int B = 2;

  // ---------------- clock / reset ----------------
  logic        iclk = 1'b0;
  logic        ireset = 1'b0;
  logic        iclkena = 1'b1;
  logic        iflush = 1'b0;
  logic        iwrite = 1'b0;
  logic        iwfull = 1'b0;
  logic [7:0]  iwaddr = '0;
  logic [7:0]  iwdata = '0;
  logic [7:0]  iwtag = '0;
  logic        iread = 1'b0;
  logic        irempty = 1'b0;
  logic [15:0] iraddr = '0;

  always #5 iclk = ~iclk;

  logic [15:0] d0_ordata, d1_ordata;
  logic        d0_ordval, d1_ordval;
  logic [7:0]  d0_ortag, d1_ortag;
  logic        d0_oempty, d0_oemptya, d0_ofull, d0_ofulla, d0_oerr;
  logic        d1_oempty, d1_oemptya, d1_ofull, d1_ofulla, d1_oerr;
`ifdef CCSDS_TURBO_ENC_BUF_USEDW_EN
  logic [1:0]  d0_ousedw, d1_ousedw;
`endif

  ccsds_turbo_enc_buffer_mp #(.pPIPE(0)) dut0 (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .iflush(iflush),
    .iwrite(iwrite), .iwfull(iwfull), .iwaddr(iwaddr), .iwdata(iwdata),
    .iwtag(iwtag), .iread(iread), .irempty(irempty), .iraddr(iraddr),
    .ordata(d0_ordata), .ordval(d0_ordval), .ortag(d0_ortag),
    .oempty(d0_oempty), .oemptya(d0_oemptya), .ofull(d0_ofull),
    .ofulla(d0_ofulla), .oerr(d0_oerr)
`ifdef CCSDS_TURBO_ENC_BUF_USEDW_EN
    , .ousedw(d0_ousedw)
`endif
  );

  ccsds_turbo_enc_buffer_mp #(.pPIPE(1)) dut1 (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .iflush(iflush),
    .iwrite(iwrite), .iwfull(iwfull), .iwaddr(iwaddr), .iwdata(iwdata),
    .iwtag(iwtag), .iread(iread), .irempty(irempty), .iraddr(iraddr),
    .ordata(d1_ordata), .ordval(d1_ordval), .ortag(d1_ortag),
    .oempty(d1_oempty), .oemptya(d1_oemptya), .ofull(d1_ofull),
    .ofulla(d1_ofulla), .oerr(d1_oerr)
`ifdef CCSDS_TURBO_ENC_BUF_USEDW_EN
    , .ousedw(d1_ousedw)
`endif
  );

  // ---------------- scoreboard / reference model ----------------
  int n_chk = 0;
  int n_pass = 0;

  logic [7:0] m_mem [B][256];
  bit         m_val [B][256];
  logic [7:0] m_tag [B];
  int         m_wptr, m_rptr, m_used;
  bit         m_err;
  bit         hv[$];
  bit         hok[$];
  logic [15:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic hist_clear();
    hv.delete(); hok.delete(); exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      hv.push_back(1'b0); hok.push_back(1'b0); exp_q.push_back('0);
    end
  endtask

  task automatic model_reset();
    m_wptr = 0; m_rptr = 0; m_used = 0; m_err = 1'b0;
    hist_clear();
  endtask

  task automatic hist_push(input bit v, input bit ok, input logic [15:0] d);
    hv.push_back(v); hok.push_back(ok); exp_q.push_back(d);
    if (hv.size() > 4) begin
      void'(hv.pop_front()); void'(hok.pop_front()); void'(exp_q.pop_front());
    end
  endtask

  // Apply the current inputs to the model as one rising edge
  task automatic model_edge();
    bit full, empty, aw, ar, ok;
    logic [7:0] a0, a1;
    if (!iclkena) return;
    if (iflush) begin
      m_wptr = 0; m_rptr = 0; m_used = 0; m_err = 1'b0;
      hist_clear();
      return;
    end
    a0 = iraddr[7:0];
    a1 = iraddr[15:8];
    ok = m_val[m_rptr][a0] && m_val[m_rptr][a1] && (m_used > 0);
    hist_push(iread, ok, {m_mem[m_rptr][a1], m_mem[m_rptr][a0]});
    full  = (m_used == B);
    empty = (m_used == 0);
    if (iwrite && !full) begin
      m_mem[m_wptr][iwaddr] = iwdata;
      m_val[m_wptr][iwaddr] = 1'b1;
    end
    aw = iwfull && !full;
    ar = irempty && !empty;
    if ((iwfull && full) || (irempty && empty)) m_err = 1'b1;
    if (aw) begin
      m_tag[m_wptr] = iwtag;
      m_wptr = (m_wptr + 1) % B;
    end
    if (ar) m_rptr = (m_rptr + 1) % B;
    m_used = m_used + int'(aw) - int'(ar);
  endtask

  task automatic check_all();
    int n;
    n = hv.size();
    chk("d0_oempty",  d0_oempty,  m_used < B);
    chk("d0_oemptya", d0_oemptya, m_used == 0);
    chk("d0_ofull",   d0_ofull,   m_used > 0);
    chk("d0_ofulla",  d0_ofulla,  m_used == B);
    chk("d0_oerr",    d0_oerr,    m_err);
    chk("d1_ofull",   d1_ofull,   m_used > 0);
    chk("d1_ofulla",  d1_ofulla,  m_used == B);
    chk("d1_oerr",    d1_oerr,    m_err);
    chk("d1_oemptya", d1_oemptya, m_used == 0);
    chk("d1_oempty",  d1_oempty,  m_used < B);
    chk("d0_ordval",  d0_ordval,  hv[n-1]);
    chk("d1_ordval",  d1_ordval,  hv[n-2]);
    if (hv[n-1] && hok[n-1]) chk("d0_ordata", d0_ordata, exp_q[n-1]);
    if (hv[n-2] && hok[n-2]) chk("d1_ordata", d1_ordata, exp_q[n-2]);
    if (m_used > 0) begin
      chk("d0_ortag", d0_ortag, m_tag[m_rptr]);
      chk("d1_ortag", d1_ortag, m_tag[m_rptr]);
    end
`ifdef CCSDS_TURBO_ENC_BUF_USEDW_EN
    chk("d0_ousedw", d0_ousedw, m_used);
    chk("d1_ousedw", d1_ousedw, m_used);
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    model_edge();
    @(posedge iclk);
    #1;
    check_all();
  endtask

  task automatic idle();
    iclkena = 1'b1; iflush = 1'b0; iwrite = 1'b0; iwfull = 1'b0;
    iread = 1'b0; irempty = 1'b0;
  endtask

  task automatic write_bank(input bit pat, input logic [7:0] tag);
    for (int a = 0; a < 256; a++) begin
      iwrite = 1'b1; iwaddr = a[7:0];
      iwdata = pat ? (a[7:0] ^ 8'hA5) : 8'($urandom_range(0, 255));
      tick();
    end
    iwrite = 1'b0;
    close_bank(tag);
  endtask

  task automatic close_bank(input logic [7:0] tag);
    iwfull = 1'b1; iwtag = tag;
    tick();
    iwfull = 1'b0;
  endtask

  task automatic release_bank();
    irempty = 1'b1;
    tick();
    irempty = 1'b0;
  endtask

  task automatic read_pair(input logic [7:0] a0, input logic [7:0] a1);
    iread = 1'b1; iraddr = {a1, a0};
    tick();
    iread = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int b = 0; b < B; b++)
      for (int a = 0; a < 256; a++) m_val[b][a] = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("rst_ordval1", d1_ordval, 1'b0);
    @(negedge iclk);
    ireset = 1'b1;

    // 1: one bank with a known pattern
    write_bank(1'b1, 8'h3C);
    chk("t1_oemptya", d0_oemptya, 1'b0);
    chk("t1_ortag", d0_ortag, 8'h3C);
    read_pair(8'd5, 8'd200);
    chk("t1_rdata", d0_ordata, 16'h6DA0);
    chk("t1_rdval", d0_ordval, 1'b1);
    tick();

    // 2: fill both banks, then an over-close
    write_bank(1'b0, 8'h5A);
    chk("t2_ofulla", d0_ofulla, 1'b1);
    chk("t2_oempty", d0_oempty, 1'b0);
    close_bank(8'hEE);
    chk("t2_oerr", d0_oerr, 1'b1);
    chk("t2_still_full", d0_ofulla, 1'b1);
    read_pair(8'd5, 8'd200);
    chk("t2_rdata", d0_ordata, 16'h6DA0);

    // 3: simultaneous close and release at used=2, then at used=1
    iwfull = 1'b1; irempty = 1'b1; iwtag = 8'h11;
    tick();
    chk("t3a_ofulla", d0_ofulla, 1'b0);
    chk("t3a_ortag", d0_ortag, 8'h5A);
    iwtag = 8'h77;
    tick();
    iwfull = 1'b0; irempty = 1'b0;
    chk("t3b_ofull", d0_ofull, 1'b1);
    chk("t3b_ofulla", d0_ofulla, 1'b0);
    chk("t3b_ortag", d0_ortag, 8'h77);
    chk("t3b_oerr", d0_oerr, 1'b1);

    // 4: latency with back-to-back reads and a 3-cycle clock-enable gap
    iread = 1'b1; iraddr = {8'd7, 8'd9}; tick();
    iraddr = {8'd1, 8'd2}; tick();
    iread = 1'b0;
    iclkena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_hold_v0", d0_ordval, 1'b1);
      chk("t4_hold_v1", d1_ordval, 1'b1);
    end
    iclkena = 1'b1;
    tick();
    chk("t4_v1_second", d1_ordval, 1'b1);
    tick();
    chk("t4_v1_done", d1_ordval, 1'b0);

    // 5: flush with used=2 and oerr set
    close_bank(8'h42);
    iflush = 1'b1; iwrite = 1'b1; iwfull = 1'b1;
    tick();
    idle();
    chk("t5_oemptya", d0_oemptya, 1'b1);
    chk("t5_ofull", d0_ofull, 1'b0);
    chk("t5_oerr", d0_oerr, 1'b0);

    // 6: occupancy sequence 0,1,2,1,0
    close_bank(8'hA1);
    close_bank(8'hB2);
    release_bank();
    release_bank();
    chk("t6_empty", d1_oemptya, 1'b1);

    // random phase
    for (int c = 0; c < 4000; c++) begin
      iclkena = ($urandom_range(0, 9) != 0);
      iflush  = ($urandom_range(0, 299) == 0);
      iwrite  = $urandom_range(0, 1) == 1;
      iwaddr  = 8'($urandom_range(0, 255));
      iwdata  = 8'($urandom_range(0, 255));
      iwtag   = 8'($urandom_range(0, 255));
      iwfull  = ($urandom_range(0, 39) == 0);
      irempty = ($urandom_range(0, 39) == 0);
      iread   = (m_used > 0) && ($urandom_range(0, 1) == 1);
      iraddr  = 16'($urandom_range(0, 65535));
      tick();
    end
    idle();
    tick();

    // asynchronous reset in the middle of a write
    close_bank(8'h99);
    iwrite = 1'b1;
    @(posedge iclk);
    #3;
    ireset = 1'b0;
    #1;
    model_reset();
    chk("ar_oempty", d0_oempty, 1'b1);
    chk("ar_oemptya", d0_oemptya, 1'b1);
    chk("ar_ofull", d0_ofull, 1'b0);
    chk("ar_ofulla", d0_ofulla, 1'b0);
    chk("ar_oerr", d0_oerr, 1'b0);
    chk("ar_ordval", d0_ordval, 1'b0);
    idle();
    @(negedge iclk);
    ireset = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ccsds_turbo_enc_buffer_mp.md
Name: ccsds_turbo_enc_buffer_mp

Overview:
Multi-bank encoder RAM buffer with one write port and pRPORT_N concurrent read ports. It sits between the CCSDS turbo encoder input framer and the constituent encoders. Each read port has its own RAM copy, so every port sees a full, independent view of the current read bank. Bank swap/status logic is built in: write/read bank pointers, an occupancy counter, an overflow/underflow error flag and a synchronous flush. Also adds a per-port read-valid pipeline.

Parameters:
pADDR_W, 8, word address width inside one bank
pDATA_W, 8, data word width
pTAG_W, 8, per-bank tag width
pBNUM_W, 1, log2 of bank count B=2**pBNUM_W (range 1..4)
pRPORT_N, 2, number of concurrent read ports (range 1..8); one RAM copy per port
pPIPE, 0, 0: read latency 1 cycle; 1: extra output register, latency 2

Ports:
iclk  in  1  clock
ireset  in  1  asynchronous active-low reset
iclkena  in  1  clock enable for all sequential logic
iflush  in  1  synchronous flush: empties all banks
iwrite  in  1  write strobe for iwdata at iwaddr in the current write bank
iwfull  in  1  current write bank complete: latch iwtag and advance the write bank
iwaddr  in  pADDR_W  write word address
iwdata  in  pDATA_W  write data
iwtag  in  pTAG_W  tag of the bank being closed
iread  in  1  read strobe, shared by all ports
irempty  in  1  current read bank consumed: release it and advance the read bank
iraddr  in  pRPORT_N*pADDR_W  packed read addresses; port k uses bits [k*pADDR_W +: pADDR_W]
ordata  out  pRPORT_N*pDATA_W  packed read data, same packing as iraddr
ordval  out  1  ordata valid, iread delayed by the read latency
ortag  out  pTAG_W  tag of the current read bank
oempty  out  1  at least one bank free for writing
oemptya  out  1  all banks free
ofull  out  1  at least one bank full (readable)
ofulla  out  1  all banks full
oerr  out  1  sticky error: iwfull while ofulla, or irempty while oemptya

Behaviour:
- State: wptr, rptr (pBNUM_W bits each, wrap modulo B); used (pBNUM_W+1 bits, range 0..B); oerr.
- Reset (ireset=0, async): wptr=rptr=0, used=0, oerr=0, ordval pipe=0.
  - Reset outputs: oempty=1, oemptya=1, ofull=0, ofulla=0, oerr=0, ordval=0.
  - ortag and ordata are undefined after reset (RAM contents are not reset).
- All updates occur only when iclkena=1. Reset mid-operation discards all banks; no partial-bank recovery.
- Flags are combinational from used:
  - oempty = (used<B)
  - oemptya = (used==0)
  - ofull = (used>0)
  - ofulla = (used==B)
- Accepted close (acc_w) = iwfull & ~ofulla:
  - wptr+=1
  - tag RAM[wptr] <= iwtag
- Accepted release (acc_r) = irempty & ~oemptya:
  - rptr+=1
- used update:
  - +1 if acc_w only
  - -1 if acc_r only
  - unchanged if both or neither
  - Simultaneous iwfull and irempty when used==B: the release is accepted and the close is rejected (flags are evaluated on the pre-update value).
- Rejected iwfull (at ofulla) or rejected irempty (at oemptya) sets oerr=1. oerr clears only on reset or iflush.
- Writes:
  - iwrite writes iwdata to address {wptr,iwaddr} in all pRPORT_N RAM copies.
  - iwrite is suppressed while ofulla=1, to protect the bank being read.
  - Write and iwfull in the same cycle: the data lands in the old bank.
- Reads:
  - Port k reads {rptr,iraddr[k]} from its own RAM copy; registered, latency 1+pPIPE.
  - Read-during-write to the same address returns don't-care data. Address conflicts are impossible except at the used==0 wrap, so this is acceptable.
- ordval = iread delayed 1+pPIPE enabled cycles.
- ortag = tagRAM[rptr], combinational; it changes the cycle after acc_r.
- iflush (synchronous, highest priority):
  - wptr=rptr=0, used=0, oerr=0, ordval pipe cleared.
  - Concurrent iwfull/irempty/iwrite are ignored.

Optional Feature:
Macro CCSDS_TURBO_ENC_BUF_USEDW_EN.
- Defined: adds output port ousedw [pBNUM_W:0] carrying the used count directly. Its reset value is 0, and it is updated with used.
- Undefined: the port does not exist, and the flags are the only occupancy indication.
- Core behaviour is identical in both builds.

Test Plan:
1. Reset, then pBNUM_W=1, pRPORT_N=2:
   - Write 256 words (data=addr^8'hA5), then iwfull with iwtag=8'h3C.
   - Required: oemptya=0, ofull=1, oempty=1, ortag=8'h3C.
   - Port0 addr 5 and port1 addr 200, with iread: ordata={8'h6D,8'hA0} and ordval=1 one cycle later.
2. Close 2 banks (B=2): ofulla=1, oempty=0. A third iwfull gives oerr=1, used stays 2, and bank-0 data is unchanged on read.
3. used=2; assert iwfull and irempty in the same cycle: release accepted, close rejected, used=1, oerr=1. Repeat at used=1: used stays 1, wptr and rptr both advance, oerr stays set.
4. pPIPE=1: iread pulses at cycles 10 and 11 give ordval high at cycles 12 and 13. With iclkena low for 3 cycles in between, ordval and ordata hold and the latency stretches by 3.
5. Assert iflush with used=2 and oerr=1: next cycle oemptya=1, ofull=0, oerr=0. Assert ireset low asynchronously mid-write: all flags return to reset values with no clock edge.
6. With CCSDS_TURBO_ENC_BUF_USEDW_EN defined: ousedw follows the sequence 0,1,2,1,0 across close, close, release, release.
